// File: rtl/cnn_class_head.sv
// cnn_class_head
//   Classification back-end for the CNN pipeline. Consumes a frame of
//   NUM_CLASS signed scores (one per accepted cycle), reports the argmax class
//   and its score one cycle after the last score, counts classified frames and
//   raises a sticky end flag once N_FRAMES frames have been classified.
//
//   Optional feature: define CLASS_HEAD_TOP2_EN to track the second-best score
//   and report the best/second margin plus a low-confidence flag. Without the
//   macro o_margin and o_low_conf are tied to 0.
//
// Ports
//   clk              rising-edge clock
//   global_rst       synchronous active-high reset
//   i_rst_processEnd synchronous soft clear between processes
//   ce               clock enable (score input ignored and state held when low)
//   i_score          signed score, SCORE_BW bits
//   i_score_en       i_score valid this cycle
//   o_class          argmax index of the last completed frame
//   o_max_score      winning score of the last completed frame
//   o_class_en       one-cycle result strobe
//   o_class_end      sticky: N_FRAMES frames classified
//   o_frame_cnt      completed frames, saturating
//   o_busy           frame partially received
//   o_margin         best minus second-best score (unsigned, SCORE_BW+1 bits)
//   o_low_conf       o_margin < MARGIN_TH
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no frame in progress; next accepted score starts a frame
// S_ACCUM | frame partially received; scores compared against running best

module cnn_class_head #(
  parameter int NUM_CLASS = 10,
  parameter int SCORE_BW  = 16,
  parameter int N_FRAMES  = 1,
  parameter int FCNT_BW   = 16,
  parameter int MARGIN_TH = 4,
  localparam int IDX_BW   = $clog2(NUM_CLASS)
) (
  input  logic                       clk,
  input  logic                       global_rst,
  input  logic                       i_rst_processEnd,
  input  logic                       ce,
  input  logic signed [SCORE_BW-1:0] i_score,
  input  logic                       i_score_en,
  output logic        [IDX_BW-1:0]   o_class,
  output logic signed [SCORE_BW-1:0] o_max_score,
  output logic                       o_class_en,
  output logic                       o_class_end,
  output logic        [FCNT_BW-1:0]  o_frame_cnt,
  output logic                       o_busy,
  output logic        [SCORE_BW:0]   o_margin,
  output logic                       o_low_conf
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic [IDX_BW-1:0]  LAST_IDX = IDX_BW'(NUM_CLASS - 1);
  localparam logic [FCNT_BW-1:0] FCNT_MAX = '1;
  localparam logic [FCNT_BW-1:0] FCNT_END = FCNT_BW'(N_FRAMES);

  state_t                     state_q, state_d;
  logic        [IDX_BW-1:0]   idx_q, idx_d;
  logic signed [SCORE_BW-1:0] best_q, best_d;
  logic        [IDX_BW-1:0]   best_idx_q, best_idx_d;
  logic        [IDX_BW-1:0]   class_q, class_d;
  logic signed [SCORE_BW-1:0] max_score_q, max_score_d;
  logic                       class_en_q, class_en_d;
  logic                       class_end_q, class_end_d;
  logic        [FCNT_BW-1:0]  frame_cnt_q, frame_cnt_d;

  logic                       accept;
  logic                       cand_gt;
  logic signed [SCORE_BW-1:0] run_best;
  logic        [IDX_BW-1:0]   run_idx;
  logic        [FCNT_BW-1:0]  frame_cnt_inc;

`ifdef CLASS_HEAD_TOP2_EN
  localparam logic signed [SCORE_BW-1:0] SCORE_MIN = {1'b1, {(SCORE_BW-1){1'b0}}};
  localparam logic [SCORE_BW:0]          MARGIN_LIM = (SCORE_BW+1)'(MARGIN_TH);

  logic signed [SCORE_BW-1:0] second_q, second_d;
  logic        [SCORE_BW:0]   margin_q, margin_d;
  logic                       low_conf_q, low_conf_d;
  logic signed [SCORE_BW-1:0] run_second;
  logic        [SCORE_BW:0]   run_margin;
`endif

  // soft clear outranks any score arriving in the same cycle
  assign accept   = ce & i_score_en & ~class_end_q & ~i_rst_processEnd;
  assign cand_gt  = i_score > best_q;
  // strict compare keeps the lowest index on ties
  assign run_best = cand_gt ? i_score : best_q;
  assign run_idx  = cand_gt ? idx_q : best_idx_q;
  assign frame_cnt_inc = (frame_cnt_q == FCNT_MAX) ? frame_cnt_q
                                                   : frame_cnt_q + FCNT_BW'(1);

`ifdef CLASS_HEAD_TOP2_EN
  // a displaced best becomes the runner-up
  assign run_second = cand_gt             ? best_q  :
                      (i_score > second_q) ? i_score : second_q;
  // best >= second always, so the sign-extended difference is non-negative
  assign run_margin = {run_best[SCORE_BW-1], run_best}
                    - {run_second[SCORE_BW-1], run_second};
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_d     = class_q;
    max_score_d = max_score_q;
    class_en_d  = 1'b0;
    class_end_d = class_end_q;
    frame_cnt_d = frame_cnt_q;
`ifdef CLASS_HEAD_TOP2_EN
    second_d    = second_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
`endif

    if (i_rst_processEnd) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      frame_cnt_d = '0;
      class_end_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          best_d     = i_score;
          best_idx_d = '0;
          idx_d      = IDX_BW'(1);
          state_d    = S_ACCUM;
`ifdef CLASS_HEAD_TOP2_EN
          second_d   = SCORE_MIN;
`endif
        end
        S_ACCUM: begin
          best_d     = run_best;
          best_idx_d = run_idx;
`ifdef CLASS_HEAD_TOP2_EN
          second_d   = run_second;
`endif
          if (idx_q == LAST_IDX) begin
            class_d     = run_idx;
            max_score_d = run_best;
            class_en_d  = 1'b1;
            frame_cnt_d = frame_cnt_inc;
            if (frame_cnt_inc >= FCNT_END) begin
              class_end_d = 1'b1;
            end
            idx_d   = '0;
            state_d = S_IDLE;
`ifdef CLASS_HEAD_TOP2_EN
            margin_d   = run_margin;
            low_conf_d = (run_margin < MARGIN_LIM);
`endif
          end else begin
            idx_d = idx_q + IDX_BW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_q     <= '0;
      max_score_q <= '0;
      class_en_q  <= 1'b0;
      class_end_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_q     <= class_d;
      max_score_q <= max_score_d;
      class_en_q  <= class_en_d;
      class_end_q <= class_end_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef CLASS_HEAD_TOP2_EN
  always_ff @(posedge clk) begin
    if (global_rst) begin
      second_q   <= '0;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
    end else begin
      second_q   <= second_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
    end
  end

  assign o_margin   = margin_q;
  assign o_low_conf = low_conf_q;
`else
  assign o_margin   = '0;
  assign o_low_conf = 1'b0;
`endif

  assign o_class     = class_q;
  assign o_max_score = max_score_q;
  assign o_class_en  = class_en_q;
  assign o_class_end = class_end_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = (state_q == S_ACCUM);

endmodule

// File: tb/tb_cnn_class_head.sv
module tb_cnn_class_head;

  localparam int NC = 10;
  localparam int SBW = 16;
  localparam int NFR = 3;
  localparam int FBW = 16;
  localparam int MTH = 4;

`ifdef CLASS_HEAD_TOP2_EN
  localparam bit TOP2 = 1'b1;
`else
  localparam bit TOP2 = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  global_rst = 1'b1;
  logic                  i_rst_processEnd = 1'b0;
  logic                  ce = 1'b0;
  logic signed [SBW-1:0] i_score = '0;
  logic                  i_score_en = 1'b0;
  logic        [3:0]     o_class;
  logic signed [SBW-1:0] o_max_score;
  logic                  o_class_en;
  logic                  o_class_end;
  logic        [FBW-1:0] o_frame_cnt;
  logic                  o_busy;
  logic        [SBW:0]   o_margin;
  logic                  o_low_conf;

  cnn_class_head #(
    .NUM_CLASS(NC), .SCORE_BW(SBW), .N_FRAMES(NFR), .FCNT_BW(FBW), .MARGIN_TH(MTH)
  ) dut (
    .clk(clk), .global_rst(global_rst), .i_rst_processEnd(i_rst_processEnd),
    .ce(ce), .i_score(i_score), .i_score_en(i_score_en),
    .o_class(o_class), .o_max_score(o_max_score), .o_class_en(o_class_en),
    .o_class_end(o_class_end), .o_frame_cnt(o_frame_cnt), .o_busy(o_busy),
    .o_margin(o_margin), .o_low_conf(o_low_conf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: accepted scores of the open frame plus last results
  int mq[$];
  int m_cls, m_max, m_margin, m_cnt;
  bit m_lc, m_en, m_end;

  typedef struct {
    int sc[NC];
    int cls;
    int mx;
    int mg;   // margin when the top-2 feature is built in
    bit lc;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // argmax (first occurrence) and runner-up over the other entries
  task automatic model_result(input int s[$]);
    int bi, sec;
    bi = 0;
    for (int k = 1; k < s.size(); k++) if (s[k] > s[bi]) bi = k;
    sec = -32768;
    for (int k = 0; k < s.size(); k++) if (k != bi && s[k] > sec) sec = s[k];
    m_cls = bi;
    m_max = s[bi];
    if (TOP2) begin
      m_margin = s[bi] - sec;
      m_lc = (m_margin < MTH);
    end else begin
      m_margin = 0;
      m_lc = 1'b0;
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit e,
                            input int s, input bit p);
    bit acc;
    if (r) begin
      mq.delete();
      m_cls = 0; m_max = 0; m_margin = 0; m_cnt = 0;
      m_lc = 0; m_en = 0; m_end = 0;
      return;
    end
    acc = c & e & ~m_end & ~p;
    m_en = 1'b0;
    if (p) begin
      mq.delete();
      m_cnt = 0;
      m_end = 1'b0;
    end else if (acc) begin
      mq.push_back(s);
      if (mq.size() == NC) begin
        model_result(mq);
        mq.delete();
        m_en = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt >= NFR) m_end = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit e,
                     input logic signed [SBW-1:0] s, input bit p);
    global_rst = r; ce = c; i_score_en = e; i_score = s; i_rst_processEnd = p;
    model_step(r, c, e, int'(s), p);
    @(posedge clk);
    #1;
    chk("class_en",  o_class_en, m_en);
    chk("busy",      o_busy, mq.size() > 0);
    chk("frame_cnt", o_frame_cnt, m_cnt);
    chk("class_end", o_class_end, m_end);
    chk("class",     o_class, m_cls);
    chk("max_score", o_max_score, m_max);
    chk("margin",    o_margin, m_margin);
    chk("low_conf",  o_low_conf, m_lc);
  endtask

  function automatic logic signed [SBW-1:0] rnd_score();
    int t;
    case ($urandom_range(0, 3))
      0: t = $urandom_range(0, 6) - 3;
      1: t = $urandom;
      2: t = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      default: t = $urandom_range(0, 40) - 20;
    endcase
    return SBW'(t);
  endfunction

  task automatic run_frame(input int idx);
    for (int k = 0; k < NC; k++) cyc(0, 1, 1, SBW'(vt[idx].sc[k]), 0);
  endtask

  int strobes;
  int ce_k;

  initial begin
    vt[0].sc = '{0, 5, -3, 12, 7, 12, 1, 0, -8, 2};
    vt[0].cls = 3; vt[0].mx = 12; vt[0].mg = 0; vt[0].lc = 1;
    vt[1].sc = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767};
    vt[1].cls = 9; vt[1].mx = -32767; vt[1].mg = 1; vt[1].lc = 1;
    vt[2].sc = '{0, 0, 18, 0, 0, 0, 0, 20, 0, 0};
    vt[2].cls = 7; vt[2].mx = 20; vt[2].mg = 2; vt[2].lc = 1;
    vt[3].sc = '{-5, -1, -7, -2, -9, -3, -4, -8, -6, -10};
    vt[3].cls = 1; vt[3].mx = -1; vt[3].mg = 1; vt[3].lc = 1;
    vt[4].sc = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    vt[4].cls = 0; vt[4].mx = 32767; vt[4].mg = 65535; vt[4].lc = 0;
    vt[5].sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    vt[5].cls = 9; vt[5].mx = 100; vt[5].mg = 91; vt[5].lc = 0;

    // reset state
    cyc(1, 0, 0, '0, 0);
    cyc(1, 1, 1, 16'sd7, 0);
    chk("rst_class", o_class, 0);
    chk("rst_busy", o_busy, 0);

    // table-driven frames, each after a soft clear
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, '0, 1);
      run_frame(i);
      chk("tbl_strobe", o_class_en, 1);
      chk("tbl_class", o_class, vt[i].cls);
      chk("tbl_max", o_max_score, vt[i].mx);
      chk("tbl_margin", o_margin, TOP2 ? vt[i].mg : 0);
      chk("tbl_lowconf", o_low_conf, TOP2 ? vt[i].lc : 1'b0);
      chk("tbl_fcnt", o_frame_cnt, 1);
      cyc(0, 1, 0, '0, 0);
      chk("tbl_pulse_end", o_class_en, 0);
    end

    // soft clear mid-frame after a class-3 result
    cyc(0, 1, 0, '0, 1);
    run_frame(0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, rnd_score(), 0);
    chk("mid_busy_before", o_busy, 1);
    cyc(0, 1, 1, 16'sd999, 1);
    chk("clr_busy", o_busy, 0);
    chk("clr_class_hold", o_class, 3);
    chk("clr_fcnt", o_frame_cnt, 0);
    cyc(0, 1, 0, '0, 0);
    chk("clr_no_strobe", o_class_en, 0);
    run_frame(2);
    chk("after_clr_class", o_class, 7);
    chk("after_clr_strobe", o_class_en, 1);

    // final score coincident with the soft clear
    cyc(0, 1, 0, '0, 1);
    for (int k = 0; k < NC - 1; k++) cyc(0, 1, 1, rnd_score(), 0);
    cyc(0, 1, 1, 16'sd5000, 1);
    chk("coinc_no_strobe", o_class_en, 0);
    chk("coinc_fcnt", o_frame_cnt, 0);
    cyc(0, 1, 0, '0, 0);
    chk("coinc_no_strobe2", o_class_en, 0);

    // three back-to-back frames, ce low every third cycle, then a dropped 4th
    cyc(0, 1, 0, '0, 1);
    strobes = 0;
    for (int c = 0; c < 45; c++) begin
      cyc(0, (c % 3) != 2, 1, rnd_score(), 0);
      if (o_class_en) strobes++;
    end
    chk("b2b_strobes", strobes, 3);
    chk("b2b_end", o_class_end, 1);
    chk("b2b_fcnt", o_frame_cnt, 3);
    strobes = 0;
    for (int c = 0; c < 15; c++) begin
      cyc(0, 1, 1, rnd_score(), 0);
      if (o_class_en) strobes++;
    end
    chk("end_drop_strobes", strobes, 0);
    chk("end_drop_fcnt", o_frame_cnt, 3);

    // global reset mid-frame
    cyc(0, 1, 0, '0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, rnd_score(), 0);
    cyc(1, 1, 1, 16'sd3, 0);
    chk("grst_busy", o_busy, 0);
    chk("grst_max", o_max_score, 0);
    run_frame(3);
    chk("grst_then_class", o_class, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ce_k = $urandom_range(0, 9);
      cyc(0, ce_k != 0, $urandom_range(0, 3) != 0, rnd_score(),
          $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
